sh7604_mac_ctrl: RTL

SH7604_MAC_CTRL -- requirements
Module: sh7604_mac_ctrl

---
 rtl/sh7604_mac_ctrl_if.sv | 43 ++++
 rtl/sh7604_mac_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sh7604_mac_ctrl_if.sv
// Handshake and datapath bundle between the CPU pipeline (master) and the
// MAC sequencer (slave).
//   CE_R                       rising-phase clock enable
//   REQ/OP/SAT/TGT             op request, op code, saturate flag, LDS target
//   OPND_VALID/OPND_DI         operand word valid and data
//   RD_REQ/RD_SEL              STS read request and source
//   ACK/OPND_TAKE/RD_OK        request accepted, operand consumed, read granted
//   STALL/BUSY                 pipeline stall, op in flight
//   MAC_SEL/MAC_OP/MAC_S       multiplier register select, op code, saturate
//   MAC_WE/MAC_DI              multiplier write enable and write data
interface sh7604_mac_ctrl_if;
  logic        CE_R;
  logic        REQ;
  logic [3:0]  OP;
  logic        SAT;
  logic [1:0]  TGT;
  logic        OPND_VALID;
  logic [31:0] OPND_DI;
  logic        RD_REQ;
  logic [1:0]  RD_SEL;
  logic        ACK;
  logic        OPND_TAKE;
  logic        RD_OK;
  logic        STALL;
  logic        BUSY;
  logic [1:0]  MAC_SEL;
  logic [3:0]  MAC_OP;
  logic        MAC_S;
  logic        MAC_WE;
  logic [31:0] MAC_DI;

  modport master (
    output CE_R, REQ, OP, SAT, TGT, OPND_VALID, OPND_DI, RD_REQ, RD_SEL,
    input  ACK, OPND_TAKE, RD_OK, STALL, BUSY, MAC_SEL, MAC_OP, MAC_S,
           MAC_WE, MAC_DI
  );

  modport slave (
    input  CE_R, REQ, OP, SAT, TGT, OPND_VALID, OPND_DI, RD_REQ, RD_SEL,
    output ACK, OPND_TAKE, RD_OK, STALL, BUSY, MAC_SEL, MAC_OP, MAC_S,
           MAC_WE, MAC_DI
  );
endinterface

// File: rtl/sh7604_mac_ctrl.sv
// SH7604 MAC unit sequencer: accepts multiply/accumulate ops, steps them
// through one or two operand-write phases, then waits out the multiplier
// latency before returning to idle. STS reads are granted only while idle.
//   CLK  system clock (rising edge)
//   RST  synchronous active-high reset
//   bus  sh7604_mac_ctrl_if slave modport (request, operand, read and
//        multiplier control signals)
module sh7604_mac_ctrl (
  input  logic               CLK,
  input  logic               RST,
  sh7604_mac_ctrl_if.slave   bus
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPA  = 2'd1,
    ST_OPB  = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [OP_W-1:0]   op_q,    op_d;
  logic              sat_q,   sat_d;
  logic [SEL_W-1:0]  tgt_q,   tgt_d;

  logic              is_idle, in_phase, is_clr, we, ack, rd_ok;
  logic [SEL_W-1:0]  phase_sel, mac_sel;
  logic [CNT_W-1:0]  lat;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sat_q   <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sat_q   <= sat_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sat_d    = sat_q;
    tgt_d    = tgt_q;

    is_idle  = (state_q == ST_IDLE);
    in_phase = (state_q == ST_OPA) || (state_q == ST_OPB);
    is_clr   = (op_q == 4'b1111);

    // Multiplier latency left after the last operand write
    case (op_q)
      4'b0001, 4'b0010, 4'b0011, 4'b1001: lat = CNT_W'(2);
      4'b0110, 4'b0111, 4'b1011:          lat = CNT_W'(1);
      default:                            lat = CNT_W'(0);
    endcase

    // Register targeted by the current write phase
    case (state_q)
      ST_OPA:  phase_sel = 2'b01;
      ST_OPB:  phase_sel = (op_q == 4'b0100) ? tgt_q :
                           (is_clr ? 2'b11 : 2'b10);
      default: phase_sel = 2'b00;
    endcase

    // CLRMAC has no operand, so it writes without waiting for one
    we      = in_phase && (is_clr || bus.OPND_VALID);
    ack     = is_idle && bus.REQ && !bus.RD_REQ && bus.CE_R;
    rd_ok   = bus.RD_REQ && is_idle;
    mac_sel = in_phase ? phase_sel : (rd_ok ? bus.RD_SEL : 2'b00);

    if (bus.CE_R) begin
      case (state_q)
        ST_IDLE: begin
          if (ack) begin
            op_d  = bus.OP;
            sat_d = bus.SAT;
            tgt_d = bus.TGT;
            case (bus.OP)
              4'b0001, 4'b0010, 4'b0011, 4'b1001, 4'b1011: state_d = ST_OPA;
              4'b0100, 4'b0110, 4'b0111, 4'b1111:          state_d = ST_OPB;
              default:                                     state_d = ST_IDLE;
            endcase
          end
        end
        ST_OPA: begin
          if (we) state_d = ST_OPB;
        end
        ST_OPB: begin
          if (we) begin
            if (lat != '0) begin
              state_d = ST_WAIT;
              cnt_d   = lat;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.ACK       = ack;
  assign bus.RD_OK     = rd_ok;
  assign bus.BUSY      = !is_idle;
  assign bus.STALL     = ((bus.REQ || bus.RD_REQ) && !is_idle) ||
                         (bus.REQ && bus.RD_REQ && is_idle);
  assign bus.MAC_WE    = we;
  assign bus.OPND_TAKE = we && bus.CE_R && !is_clr;
  assign bus.MAC_SEL   = mac_sel;
  assign bus.MAC_OP    = op_q;
  assign bus.MAC_S     = sat_q;
  assign bus.MAC_DI    = bus.OPND_DI;

endmodule
